// File: rtl/mod_updown_counter.sv
// Modulo-MOD up/down counter with range-checked parallel load, a load-error
// pulse and registered BCD digits. Carry/borrow are combinational so that
// stages (seconds -> minutes -> hours) cascade and wrap on the same edge.
module mod_updown_counter #(
  parameter int MOD   = 60,
  parameter int WIDTH = 6
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_up,
  input  logic             i_down,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_count,
  output logic [3:0]       o_tens,
  output logic [3:0]       o_ones,
  output logic             o_carryup,
  output logic             o_borrowdown,
  output logic             o_load_err
);

  // Reject unsupported moduli and counts that cannot hold MOD-1.
  generate
    if (MOD < 2 || MOD > 100 || (64'(1) << WIDTH) < 64'(MOD)) begin : g_bad_params
      $error("mod_updown_counter: MOD must be 2..100 and 2**WIDTH >= MOD");
    end
  endgenerate

  localparam logic [WIDTH-1:0] COUNT_MAX  = WIDTH'(MOD - 1);
  // One extra bit so MOD == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   LOAD_LIMIT = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] count_q, count_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic             load_err_q, load_err_d;
  logic             load_ok;
  logic             at_max;
  logic             at_min;
  logic [6:0]       count_bin;

  assign load_ok = ({1'b0, i_load_val} < LOAD_LIMIT);
  assign at_max  = (count_q == COUNT_MAX);
  assign at_min  = (count_q == '0);

  // Next-count selection: load beats up/down, up+down together clears.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; an unassigned path would infer a latch.
    count_d    = count_q;
    load_err_d = 1'b0;
    if (i_load) begin
      if (load_ok) count_d    = i_load_val;
      else         load_err_d = 1'b1;
    end else begin
      unique case ({i_up, i_down})
        2'b11:   count_d = '0;
        2'b10:   count_d = at_max ? '0 : count_q + 1'b1;
        2'b01:   count_d = at_min ? COUNT_MAX : count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Decimal digits of the next count, so digits and binary update together.
  always_comb begin
    count_bin = 7'(count_d);
    tens_d    = 4'(count_bin / 7'd10);
    ones_d    = 4'(count_bin % 7'd10);
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      count_q    <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      load_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the
      // pre-edge values, independent of statement order.
      count_q    <= count_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      load_err_q <= load_err_d;
    end
  end

  assign o_count      = count_q;
  assign o_tens       = tens_q;
  assign o_ones       = ones_q;
  assign o_load_err   = load_err_q;
  assign o_carryup    = !i_load & i_up & !i_down & at_max;
  assign o_borrowdown = !i_load & !i_up & i_down & at_min;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: a seconds stage (MOD 60) optionally cascaded
// into an hours stage (MOD 24). A driver pushes expected results into a queue
// from an arithmetic reference model; a monitor pops and compares each cycle.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rstn;
  logic       casc;

  logic       s_up, s_down, s_load;
  logic [5:0] s_val;
  logic [5:0] s_count;
  logic [3:0] s_tens, s_ones;
  logic       s_cy, s_bw, s_err;

  logic       h_up_in, h_down_in, h_load;
  logic       h_up, h_down;
  logic [4:0] h_val;
  logic [4:0] h_count;
  logic [3:0] h_tens, h_ones;
  logic       h_cy, h_bw, h_err;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int   s_cnt; logic s_err; logic s_cy; logic s_bw;
    int   h_cnt; logic h_err; logic h_cy; logic h_bw;
  } exp_t;

  exp_t q[$];
  int   m_s = 0;
  int   m_h = 0;

  always #5 clk = ~clk;

  assign h_up   = casc ? s_cy : h_up_in;
  assign h_down = casc ? s_bw : h_down_in;

  mod_updown_counter #(.MOD(60), .WIDTH(6)) u_sec (
    .i_clk(clk), .i_rstn(rstn), .i_up(s_up), .i_down(s_down),
    .i_load(s_load), .i_load_val(s_val), .o_count(s_count),
    .o_tens(s_tens), .o_ones(s_ones), .o_carryup(s_cy),
    .o_borrowdown(s_bw), .o_load_err(s_err)
  );

  mod_updown_counter #(.MOD(24), .WIDTH(5)) u_hr (
    .i_clk(clk), .i_rstn(rstn), .i_up(h_up), .i_down(h_down),
    .i_load(h_load), .i_load_val(h_val), .o_count(h_count),
    .o_tens(h_tens), .o_ones(h_ones), .o_carryup(h_cy),
    .o_borrowdown(h_bw), .o_load_err(h_err)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: plain modular arithmetic on integers.
  function automatic void ref_next(input int c, input int modv, input logic l,
                                   input logic u, input logic d, input int v,
                                   output int n, output logic err);
    n   = c;
    err = 1'b0;
    if (l) begin
      if (v < modv) n = v;
      else          err = 1'b1;
    end else if (u && d) n = 0;
    else if (u)          n = (c + 1) % modv;
    else if (d)          n = (c + modv - 1) % modv;
  endfunction

  task automatic step(input logic su, input logic sd, input logic sl, input int sv,
                      input logic hu, input logic hd, input logic hl, input int hv,
                      input logic cas);
    exp_t e;
    logic eu, ed;
    int   n;
    @(negedge clk);
    s_up = su; s_down = sd; s_load = sl; s_val = 6'(sv);
    h_up_in = hu; h_down_in = hd; h_load = hl; h_val = 5'(hv);
    casc = cas;
    e.s_cy = !sl && su && !sd && (m_s == 59);
    e.s_bw = !sl && !su && sd && (m_s == 0);
    eu = cas ? e.s_cy : hu;
    ed = cas ? e.s_bw : hd;
    e.h_cy = !hl && eu && !ed && (m_h == 23);
    e.h_bw = !hl && !eu && ed && (m_h == 0);
    ref_next(m_s, 60, sl, su, sd, sv, n, e.s_err); m_s = n; e.s_cnt = n;
    ref_next(m_h, 24, hl, eu, ed, hv, n, e.h_err); m_h = n; e.h_cnt = n;
    q.push_back(e);
  endtask

  // Monitor: combinational flags before the edge, registers just after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("sec_carry",  s_cy, e.s_cy);
        check("sec_borrow", s_bw, e.s_bw);
        check("hr_carry",   h_cy, e.h_cy);
        check("hr_borrow",  h_bw, e.h_bw);
        @(posedge clk);
        #1;
        check("sec_count", s_count, e.s_cnt);
        check("sec_tens",  s_tens,  e.s_cnt / 10);
        check("sec_ones",  s_ones,  e.s_cnt % 10);
        check("sec_err",   s_err,   e.s_err);
        check("hr_count",  h_count, e.h_cnt);
        check("hr_tens",   h_tens,  e.h_cnt / 10);
        check("hr_ones",   h_ones,  e.h_cnt % 10);
        check("hr_err",    h_err,   e.h_err);
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_sec_count"}, s_count, 0);
    check({tag, "_sec_tens"},  s_tens,  0);
    check({tag, "_sec_ones"},  s_ones,  0);
    check({tag, "_sec_err"},   s_err,   0);
    check({tag, "_sec_carry"}, s_cy,    0);
    check({tag, "_hr_count"},  h_count, 0);
    check({tag, "_hr_err"},    h_err,   0);
  endtask

  initial begin
    rstn = 1'b0; casc = 1'b0;
    s_up = 0; s_down = 0; s_load = 0; s_val = '0;
    h_up_in = 0; h_down_in = 0; h_load = 0; h_val = '0;
    #12;
    check_zero("reset");
    rstn = 1'b1;

    // Up-count through the full seconds range and back to zero.
    for (int i = 0; i < 61; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Hours down from zero wraps to 23 then 22.
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Load range checks: 17, 42 accepted; 60 and 63 rejected (hours: 24, 31).
    step(0, 0, 1, 17, 0, 0, 1, 5,  0);
    step(0, 0, 1, 42, 0, 0, 1, 23, 0);
    step(0, 0, 1, 60, 0, 0, 1, 24, 0);
    step(0, 0, 1, 63, 0, 0, 1, 31, 0);
    // Load beats up at count 59; then up+down clears.
    step(0, 0, 1, 59, 0, 0, 0, 0, 0);
    step(1, 0, 1, 5,  0, 0, 0, 0, 0);
    step(1, 1, 0, 0,  1, 1, 0, 0, 0);
    // Cascade 23:59 + one up -> 0:0 on the same edge.
    step(0, 0, 1, 59, 0, 0, 1, 23, 0);
    step(1, 0, 0, 0,  0, 0, 0, 0,  1);
    // Cascaded down-wrap 0:0 -> 23:59.
    step(0, 1, 0, 0,  0, 0, 0, 0,  1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(0, 63),
           1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(0, 31),
           1'($urandom));
    end

    // Async reset between edges while a load error is showing.
    step(0, 0, 1, 33, 0, 0, 1, 13, 0);
    step(0, 0, 1, 60, 0, 0, 1, 30, 0);
    @(posedge clk);
    #2;
    @(negedge clk);
    s_up = 0; s_down = 0; s_load = 0; h_up_in = 0; h_down_in = 0; h_load = 0; casc = 0;
    #2;
    rstn = 1'b0;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    rstn = 1'b1;
    m_s = 0;
    m_h = 0;
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 1, 0, 0, 0);

    @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
